hilo_div_unit: RTL



---
 rtl/hilo_div_unit_pkg.sv | 40 ++++
 rtl/hilo_div_unit_step.sv | 25 ++
 rtl/hilo_div_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO divide sequencer: state encoding,
// iteration count and the operation decode helpers used by ID/EX.
package hilo_div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    BUSY    = 2'd2,
    DONE    = 2'd3
  } Div_state_t;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MFHI  = 4'd1,
    OP_MFLO  = 4'd2,
    OP_MTHI  = 4'd3,
    OP_MTLO  = 4'd4,
    OP_MULT  = 4'd5,
    OP_MULTU = 4'd6,
    OP_DIV   = 4'd7,
    OP_DIVU  = 4'd8
  } Oper_t;

  function automatic logic need_write_hilo(input Oper_t oper);
    case (oper)
      OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: need_write_hilo = 1'b1;
      default:                                              need_write_hilo = 1'b0;
    endcase
  endfunction

  function automatic logic need_div(input Oper_t oper);
    case (oper)
      OP_DIV, OP_DIVU: need_div = 1'b1;
      default:         need_div = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hilo_div_unit_step.sv
// One radix-2 restoring division step on the {remainder, quotient} partial
// register: shift left, trial-subtract the divisor, keep it if non-negative.
module hilo_div_unit_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0]  part_i,
  input  logic [DATA_W-1:0]  divisor_i,
  output logic [2*DATA_W:0]  part_o
);

  logic [2*DATA_W+1:0] shifted_s;
  logic [DATA_W+1:0]   diff_s;

  // Shift, trial subtract and restore
  always_comb begin
    shifted_s = {part_i, 1'b0};
    diff_s    = shifted_s[2*DATA_W+1:DATA_W] - {2'b00, divisor_i};
    if (!diff_s[DATA_W+1]) begin
      part_o = {diff_s[DATA_W:0], shifted_s[DATA_W-1:1], 1'b1};
    end else begin
      part_o = shifted_s[2*DATA_W:0];
    end
  end

endmodule

// File: rtl/hilo_div_unit.sv
// Iterative DIV/DIVU sequencer for EX: magnitudes are divided unsigned over
// DATA_W steps, then signs are applied; result is {hi, lo} = {rem, quo}.
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              annul,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              ready,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ZERO     = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  Div_state_t          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                sgn_q, neg_dvd_q, neg_dvs_q;
  logic [2*DATA_W:0]   part_q;
  logic [2*DATA_W:0]   part_d;
  logic [DATA_W-1:0]   dvs_q;
  logic                busy_q, ready_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [DATA_W-1:0]   dvd_abs_s, dvs_abs_s, quo_fix_s, rem_fix_s;

  hilo_div_unit_step #(.DATA_W(DATA_W)) u_step (
    .part_i    (part_q),
    .divisor_i (dvs_q),
    .part_o    (part_d)
  );

  // Operand magnitudes at start and signed fixup of the final step result
  always_comb begin
    if (signed_div && dividend[DATA_W-1]) dvd_abs_s = ~dividend + ONE;
    else                                  dvd_abs_s = dividend;
    if (signed_div && divisor[DATA_W-1])  dvs_abs_s = ~divisor + ONE;
    else                                  dvs_abs_s = divisor;
    if (sgn_q && (neg_dvd_q != neg_dvs_q)) quo_fix_s = ~part_d[DATA_W-1:0] + ONE;
    else                                   quo_fix_s = part_d[DATA_W-1:0];
    if (sgn_q && neg_dvd_q) rem_fix_s = ~part_d[2*DATA_W-1:DATA_W] + ONE;
    else                    rem_fix_s = part_d[2*DATA_W-1:DATA_W];
  end

  // Sequencer FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      sgn_q     <= 1'b0;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
      part_q    <= {(2*DATA_W+1){1'b0}};
      dvs_q     <= ZERO;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      hi_q      <= ZERO;
      lo_q      <= ZERO;
    end else if (annul) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sgn_q     <= signed_div;
            neg_dvd_q <= dividend[DATA_W-1];
            neg_dvs_q <= divisor[DATA_W-1];
            dvs_q     <= dvs_abs_s;
            cnt_q     <= {CNT_W{1'b0}};
            busy_q    <= 1'b1;
            // Divide-by-zero keeps the raw dividend so hi can echo it
            if (divisor == ZERO) begin
              part_q  <= {{(DATA_W+1){1'b0}}, dividend};
              state_q <= DIVZERO;
            end else begin
              part_q  <= {{(DATA_W+1){1'b0}}, dvd_abs_s};
              state_q <= BUSY;
            end
          end
        end
        DIVZERO: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          hi_q    <= part_q[DATA_W-1:0];
          lo_q    <= ALL_ONES;
        end
        BUSY: begin
          part_q <= part_d;
          cnt_q  <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            hi_q    <= rem_fix_s;
            lo_q    <= quo_fix_s;
          end
        end
        DONE: begin
          if (!start) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign hi_o  = hi_q;
  assign lo_o  = lo_q;

endmodule
